// File: rtl/store_buffer_if.sv
// Store buffer port bundle: pipeline store/load side plus data-memory write side.
// master: pipeline/control view (drives stores, loads, mem_busy).
// slave : buffer view (drives ready, forwarding/stall, memory write port, status).
interface store_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic              ld_stall;
  logic              mem_busy;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write;
  logic              empty;
  logic [CNT_W-1:0]  count;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_busy,
    input  st_ready, ld_hit, ld_data, ld_stall, mem_address, mem_write_data,
           mem_write, empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_busy,
    output st_ready, ld_hit, ld_data, ld_stall, mem_address, mem_write_data,
           mem_write, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// Purpose : posted-write FIFO between MEM-stage control and the word-addressed data memory.
// Latency : store accepted in 1 cycle, earliest memory write the cycle after; loads see pending stores combinationally.
// Backpressure: st_ready=0 when full (no pass-through on pop); drain stalls while mem_busy.
// Ports   : CLK, RST_N (async active-low); bus (store_buffer_if.slave) carries st_*, ld_*, mem_*, empty, count.
// Config  : STORE_BUF_FWD_EN defined -> load forwarding (ld_hit/ld_data); undefined -> ld_stall on pending match.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          CLK,
  input  logic          RST_N,
  store_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  // Byte-offset bits do not take part in the word compare.
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           entry_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             is_empty;
  logic             push;
  logic             pop;
  logic             any_match;
`ifdef STORE_BUF_FWD_EN
  logic [DATA_W-1:0] match_data;
`endif

  // Full blocks stores even when the head drains this cycle, keeping st_ready off the mem_busy path.
  assign full     = (count_q == FULL_CNT);
  assign is_empty = (count_q == '0);
  assign push     = bus.st_valid && !full;
  assign pop      = !is_empty && !bus.mem_busy;

  assign bus.st_ready       = !full;
  assign bus.empty          = is_empty;
  assign bus.count          = count_q;
  assign bus.mem_write      = pop;
  assign bus.mem_address    = entry_q[head_q].addr;
  assign bus.mem_write_data = entry_q[head_q].data;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      if (push) begin
        entry_q[tail_q] <= '{addr: bus.st_addr, data: bus.st_data};
        tail_q          <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Walk the live entries oldest-to-newest; the last hit wins, which is the
  // newest store to that word. The head being drained this cycle still counts.
  always_comb begin
    any_match = 1'b0;
`ifdef STORE_BUF_FWD_EN
    match_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count_q) &&
          (((entry_q[head_q + PTR_W'(k)].addr ^ bus.ld_addr) & WORD_MASK) == '0)) begin
        any_match = 1'b1;
`ifdef STORE_BUF_FWD_EN
        match_data = entry_q[head_q + PTR_W'(k)].data;
`endif
      end
    end
  end

`ifdef STORE_BUF_FWD_EN
  assign bus.ld_hit   = bus.ld_valid && any_match;
  assign bus.ld_data  = (bus.ld_valid && any_match) ? match_data : '0;
  assign bus.ld_stall = 1'b0;
`else
  assign bus.ld_hit   = 1'b0;
  assign bus.ld_data  = '0;
  assign bus.ld_stall = bus.ld_valid && any_match;
`endif
endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) sb_if ();

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (sb_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: the pending stores as a plain queue, oldest first.
  logic [ADDR_W-1:0] q_addr[$];
  logic [DATA_W-1:0] q_data[$];
  // Memory writes observed from the DUT, in order.
  logic [ADDR_W-1:0] wr_addr[$];
  logic [DATA_W-1:0] wr_data[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state update on the clock edge, from inputs held stable around it.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_addr.delete();
      q_data.delete();
    end else begin
      int n;
      bit do_pop, do_push;
      n       = q_addr.size();
      do_pop  = (n > 0) && !sb_if.mem_busy;
      do_push = sb_if.st_valid && (n < DEPTH);
      if (do_pop) begin
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
      end
      if (do_push) begin
        q_addr.push_back(sb_if.st_addr);
        q_data.push_back(sb_if.st_data);
      end
    end
  end

  // Per-cycle comparison against the model on the falling edge.
  always @(negedge CLK) begin
    if (RST_N) begin
      int n;
      bit found;
      logic [DATA_W-1:0] fdata;
      n     = q_addr.size();
      found = 1'b0;
      fdata = '0;
      for (int i = 0; i < n; i++) begin
        if ((q_addr[i] >> 2) == (sb_if.ld_addr >> 2)) begin
          found = 1'b1;
          fdata = q_data[i];
        end
      end
      check("st_ready", sb_if.st_ready, n < DEPTH);
      check("empty", sb_if.empty, n == 0);
      check("count", sb_if.count, n);
      check("mem_write", sb_if.mem_write, (n > 0) && !sb_if.mem_busy);
      if (n > 0) begin
        check("mem_address", sb_if.mem_address, q_addr[0]);
        check("mem_write_data", sb_if.mem_write_data, q_data[0]);
      end
`ifdef STORE_BUF_FWD_EN
      check("ld_hit", sb_if.ld_hit, sb_if.ld_valid && found);
      check("ld_data", sb_if.ld_data, (sb_if.ld_valid && found) ? fdata : '0);
      check("ld_stall", sb_if.ld_stall, 0);
`else
      check("ld_hit", sb_if.ld_hit, 0);
      check("ld_data", sb_if.ld_data, 0);
      check("ld_stall", sb_if.ld_stall, sb_if.ld_valid && found);
`endif
      if (sb_if.mem_write === 1'b1) begin
        wr_addr.push_back(sb_if.mem_address);
        wr_data.push_back(sb_if.mem_write_data);
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    sb_if.st_valid = 1'b1;
    sb_if.st_addr  = a;
    sb_if.st_data  = d;
    cyc();
    sb_if.st_valid = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_write(input int idx, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (idx < wr_addr.size()) begin
      check($sformatf("wr%0d_addr", idx), wr_addr[idx], a);
      check($sformatf("wr%0d_data", idx), wr_data[idx], d);
    end else begin
      check($sformatf("wr%0d_present", idx), 0, 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int stalls;
    sb_if.st_valid = 1'b0;
    sb_if.st_addr  = '0;
    sb_if.st_data  = '0;
    sb_if.ld_valid = 1'b0;
    sb_if.ld_addr  = '0;
    sb_if.mem_busy = 1'b0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_count", sb_if.count, 0);
    check("rst_empty", sb_if.empty, 1);
    check("rst_st_ready", sb_if.st_ready, 1);
    check("rst_mem_write", sb_if.mem_write, 0);
    check("rst_ld_hit", sb_if.ld_hit, 0);
    check("rst_ld_stall", sb_if.ld_stall, 0);
    check("rst_mem_address", sb_if.mem_address, 0);
    check("rst_mem_write_data", sb_if.mem_write_data, 0);
    RST_N = 1'b1;
    cyc();

    // Single store: memory write appears the cycle after acceptance
    clear_log();
    sb_if.st_valid = 1'b1;
    sb_if.st_addr  = 32'h10;
    sb_if.st_data  = 32'd327;
    #1;
    check("single_no_same_cycle_write", sb_if.mem_write, 0);
    cyc();
    sb_if.st_valid = 1'b0;
    #1;
    check("single_mem_write", sb_if.mem_write, 1);
    check("single_mem_address", sb_if.mem_address, 32'h10);
    check("single_mem_data", sb_if.mem_write_data, 32'd327);
    cyc();
    check("single_empty_after", sb_if.empty, 1);
    check("single_write_count", wr_addr.size(), 1);

    // Fill to full under mem_busy, 5th store ignored, then drain in order
    clear_log();
    sb_if.mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      store(32'h40 + 32'(4 * i), 32'd1000 + 32'(i));
    end
    check("full_count", sb_if.count, 4);
    check("full_st_ready", sb_if.st_ready, 0);
    store(32'h80, 32'd9999);
    check("full_count_after_5th", sb_if.count, 4);
    sb_if.mem_busy = 1'b0;
    repeat (6) cyc();
    check("fill_write_count", wr_addr.size(), 4);
    check_write(0, 32'h40, 32'd1000);
    check_write(1, 32'h44, 32'd1001);
    check_write(2, 32'h48, 32'd1002);
    check_write(3, 32'h4c, 32'd1003);
    check("fill_empty_after", sb_if.empty, 1);

    // Push and pop in the same cycle at count=2
    clear_log();
    sb_if.mem_busy = 1'b1;
    store(32'h20, 32'd1);
    store(32'h24, 32'd2);
    check("pp_count_before", sb_if.count, 2);
    sb_if.mem_busy = 1'b0;
    store(32'h28, 32'd3);
    check("pp_count_after", sb_if.count, 2);
    repeat (3) cyc();
    check("pp_write_count", wr_addr.size(), 3);
    check_write(0, 32'h20, 32'd1);
    check_write(1, 32'h24, 32'd2);
    check_write(2, 32'h28, 32'd3);

    // Two stores to the same word, then a load of that word
    clear_log();
    sb_if.mem_busy = 1'b1;
    store(32'h14, 32'd100);
    store(32'h14, 32'd47583);
`ifdef STORE_BUF_FWD_EN
    sb_if.ld_valid = 1'b1;
    sb_if.ld_addr  = 32'h17;
    #1;
    check("fwd_hit", sb_if.ld_hit, 1);
    check("fwd_data", sb_if.ld_data, 32'd47583);
    check("fwd_stall", sb_if.ld_stall, 0);
    sb_if.ld_addr = 32'h18;
    #1;
    check("fwd_miss_hit", sb_if.ld_hit, 0);
    check("fwd_miss_data", sb_if.ld_data, 0);
    cyc();
    sb_if.ld_valid = 1'b0;
    sb_if.mem_busy = 1'b0;
    repeat (3) cyc();
`else
    sb_if.ld_valid = 1'b1;
    sb_if.ld_addr  = 32'h18;
    #1;
    check("nofwd_other_word_stall", sb_if.ld_stall, 0);
    sb_if.ld_addr = 32'h14;
    #1;
    check("nofwd_stall", sb_if.ld_stall, 1);
    check("nofwd_hit", sb_if.ld_hit, 0);
    check("nofwd_data", sb_if.ld_data, 0);
    sb_if.mem_busy = 1'b0;
    stalls = 0;
    while (sb_if.ld_stall && stalls < 10) begin
      stalls++;
      cyc();
    end
    check("nofwd_stall_cycles", stalls, 2);
    check("nofwd_empty_after", sb_if.empty, 1);
    sb_if.ld_valid = 1'b0;
`endif
    check("same_word_write_count", wr_addr.size(), 2);
    check_write(0, 32'h14, 32'd100);
    check_write(1, 32'h14, 32'd47583);

    // Asynchronous reset mid-cycle with 3 entries pending
    sb_if.mem_busy = 1'b1;
    store(32'h30, 32'd7);
    store(32'h34, 32'd8);
    store(32'h38, 32'd9);
    check("rst3_count_before", sb_if.count, 3);
    clear_log();
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    sb_if.mem_busy = 1'b0;
    #1;
    check("rst3_count", sb_if.count, 0);
    check("rst3_empty", sb_if.empty, 1);
    check("rst3_mem_write", sb_if.mem_write, 0);
    cyc();
    RST_N = 1'b1;
    repeat (3) cyc();
    check("rst3_no_writes", wr_addr.size(), 0);
    check("rst3_empty_after", sb_if.empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
